uart_chan_mux: RTL and testbench

Parametrised N-channel UART framing multiplexer, the successor to the fixed three-way UART-to-TCP mux between the physical UART byte stream and the TCP stack's AXI-Stream endpoints. Ingress frames carry a one-word channel header and are demultiplexed to one of `NUM_CH` master streams. Egress frames from `NUM_CH` slave streams are arbitrated round-robin and re-emitted with the same header. Malformed ingress frames are dropped whole and counted.

---
 rtl/uart_chan_mux_pkg.sv | 22 ++
 rtl/uart_chan_mux_rr_arbiter.sv | 45 ++++
 rtl/uart_chan_mux.sv | 166 ++++++++++++++++
 tb/tb_uart_chan_mux.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_chan_mux_pkg.sv
// Shared types and constants for the N-channel UART framing multiplexer.
package uart_mux_pkg;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // Header word: channel id in the low bits, every bit above it zero.
    localparam int HDR_ID_LSB = 0;

    typedef enum logic [1:0] {
        RX_HDR,
        RX_FWD,
        RX_DROP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HDR,
        TX_FWD
    } tx_state_t;

endpackage

// File: rtl/uart_chan_mux_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] r_last;
    logic [ID_W-1:0] w_cand;
    logic            w_found;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = ID_W'((int'(r_last) + i) % N);
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                grant[w_cand]  = 1'b1;
                grant_id       = w_cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= ID_W'(N - 1);
        end else if (advance && w_found) begin
            r_last <= grant_id;
        end
    end

endmodule

// File: rtl/uart_chan_mux.sv
// N-channel UART framing mux: header-routed ingress demux, round-robin egress mux
// that re-inserts the channel header, and a saturating malformed-frame counter.
module uart_chan_mux
    import uart_mux_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_CH     = 4,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [DATA_WIDTH-1:0]        uart_in_tdata,
    input  logic                         uart_in_tvalid,
    input  logic                         uart_in_tlast,
    output logic                         uart_in_tready,

    output logic [NUM_CH*DATA_WIDTH-1:0] m_tdata,
    output logic [NUM_CH-1:0]            m_tvalid,
    output logic [NUM_CH-1:0]            m_tlast,
    input  logic [NUM_CH-1:0]            m_tready,

    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]            s_tvalid,
    input  logic [NUM_CH-1:0]            s_tlast,
    output logic [NUM_CH-1:0]            s_tready,

    output logic [DATA_WIDTH-1:0]        uart_out_tdata,
    output logic                         uart_out_tvalid,
    output logic                         uart_out_tlast,
    input  logic                         uart_out_tready,

    output logic [DROP_CNT_W-1:0]        rx_drop_count
);

    rx_state_t               r_rx_state;
    logic [CH_W-1:0]         r_rx_id;
    logic [DROP_CNT_W-1:0]   r_drop_cnt;

    tx_state_t               r_tx_state;
    logic [CH_W-1:0]         r_tx_id;

    logic                    w_hdr_ok;
    logic [NUM_CH-1:0]       w_grant;
    logic [CH_W-1:0]         w_grant_id;
    logic                    w_arb_advance;
    logic [DATA_WIDTH-1:0]   w_s_tdata [NUM_CH];

    assign w_hdr_ok = (uart_in_tdata[DATA_WIDTH-1:CH_W] == '0) &&
                      (int'(uart_in_tdata[HDR_ID_LSB +: CH_W]) < NUM_CH);

    // Only the routed channel sees the ingress beat; all others stay idle at zero.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic w_rx_sel;
        logic w_tx_sel;

        assign w_rx_sel = (r_rx_state == RX_FWD) && (r_rx_id == CH_W'(k));
        assign w_tx_sel = (r_tx_state == TX_FWD) && (r_tx_id == CH_W'(k));

        assign m_tvalid[k]                         = w_rx_sel & uart_in_tvalid;
        assign m_tlast[k]                          = w_rx_sel & uart_in_tlast;
        assign m_tdata[k*DATA_WIDTH +: DATA_WIDTH] = w_rx_sel ? uart_in_tdata : '0;
        assign s_tready[k]                         = w_tx_sel & uart_out_tready;
        assign w_s_tdata[k]                        = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign uart_in_tready = (r_rx_state == RX_FWD) ? m_tready[r_rx_id] : 1'b1;
    assign rx_drop_count  = r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_HDR;
            r_rx_id    <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_rx_state)
                RX_HDR: begin
                    if (uart_in_tvalid) begin
                        if (w_hdr_ok && !uart_in_tlast) begin
                            r_rx_id    <= uart_in_tdata[HDR_ID_LSB +: CH_W];
                            r_rx_state <= RX_FWD;
                        end else begin
                            if (r_drop_cnt != DROP_CNT_MAX) begin
                                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
                            end
                            if (!uart_in_tlast) begin
                                r_rx_state <= RX_DROP;
                            end
                        end
                    end
                end
                RX_FWD: begin
                    if (uart_in_tvalid && uart_in_tready && uart_in_tlast) begin
                        r_rx_state <= RX_HDR;
                    end
                end
                RX_DROP: begin
                    if (uart_in_tvalid && uart_in_tlast) begin
                        r_rx_state <= RX_HDR;
                    end
                end
                default: r_rx_state <= RX_HDR;
            endcase
        end
    end

    // The pointer only moves when a new frame is actually granted.
    assign w_arb_advance = (r_tx_state == TX_IDLE) && (|w_grant);

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (s_tvalid),
        .advance  (w_arb_advance),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_id    <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (|w_grant) begin
                        r_tx_id    <= w_grant_id;
                        r_tx_state <= TX_HDR;
                    end
                end
                TX_HDR: begin
                    if (uart_out_tready) begin
                        r_tx_state <= TX_FWD;
                    end
                end
                TX_FWD: begin
                    if (s_tvalid[r_tx_id] && uart_out_tready && s_tlast[r_tx_id]) begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        uart_out_tdata  = '0;
        uart_out_tvalid = 1'b0;
        uart_out_tlast  = 1'b0;
        case (r_tx_state)
            TX_HDR: begin
                uart_out_tdata  = DATA_WIDTH'(r_tx_id);
                uart_out_tvalid = 1'b1;
            end
            TX_FWD: begin
                uart_out_tdata  = w_s_tdata[r_tx_id];
                uart_out_tvalid = s_tvalid[r_tx_id];
                uart_out_tlast  = s_tlast[r_tx_id];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_chan_mux.sv
// Directed bench for uart_chan_mux: scoreboard queues filled when frames are
// driven, drained by negedge monitors on every output handshake.
module tb_uart_chan_mux;

    localparam int DW  = 8;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     uart_in_tdata;
    logic              uart_in_tvalid;
    logic              uart_in_tlast;
    logic              uart_in_tready;
    logic [NCH*DW-1:0] m_tdata;
    logic [NCH-1:0]    m_tvalid;
    logic [NCH-1:0]    m_tlast;
    logic [NCH-1:0]    m_tready;
    logic [NCH*DW-1:0] s_tdata;
    logic [NCH-1:0]    s_tvalid;
    logic [NCH-1:0]    s_tlast;
    logic [NCH-1:0]    s_tready;
    logic [DW-1:0]     uart_out_tdata;
    logic              uart_out_tvalid;
    logic              uart_out_tlast;
    logic              uart_out_tready;
    logic [15:0]       rx_drop_count;

    int  n_total = 0;
    int  n_pass  = 0;
    bit  mon_en  = 1'b0;

    logic [10:0] rx_exp [$];   // {channel, tlast, tdata}
    logic [8:0]  tx_exp [$];   // {tlast, tdata}

    always #5 clk = ~clk;

    uart_chan_mux #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_in_tdata   (uart_in_tdata),
        .uart_in_tvalid  (uart_in_tvalid),
        .uart_in_tlast   (uart_in_tlast),
        .uart_in_tready  (uart_in_tready),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tlast         (m_tlast),
        .m_tready        (m_tready),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .uart_out_tdata  (uart_out_tdata),
        .uart_out_tvalid (uart_out_tvalid),
        .uart_out_tlast  (uart_out_tlast),
        .uart_out_tready (uart_out_tready),
        .rx_drop_count   (rx_drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_push(input int ch, input logic last, input logic [7:0] d);
        rx_exp.push_back({2'(ch), last, d});
    endtask

    task automatic tx_push(input logic last, input logic [7:0] d);
        tx_exp.push_back({last, d});
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_m_tvalid"},   32'(m_tvalid),        32'd0);
        check({p, "_m_tlast"},    32'(m_tlast),         32'd0);
        check({p, "_m_tdata"},    m_tdata,              32'd0);
        check({p, "_in_tready"},  32'(uart_in_tready),  32'd1);
        check({p, "_out_tvalid"}, 32'(uart_out_tvalid), 32'd0);
        check({p, "_out_tdata"},  32'(uart_out_tdata),  32'd0);
        check({p, "_out_tlast"},  32'(uart_out_tlast),  32'd0);
        check({p, "_s_tready"},   32'(s_tready),        32'd0);
        check({p, "_drop_cnt"},   32'(rx_drop_count),   32'd0);
    endtask

    // Holds one ingress beat until the DUT accepts it.
    task automatic rx_send(input logic [7:0] b, input logic last);
        bit got = 1'b0;
        uart_in_tdata  = b;
        uart_in_tvalid = 1'b1;
        uart_in_tlast  = last;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = uart_in_tready;
            tick();
        end
        if (!got) check("rx_handshake_timeout", 32'(got), 32'd1);
        uart_in_tdata  = '0;
        uart_in_tvalid = 1'b0;
        uart_in_tlast  = 1'b0;
    endtask

    // Source model: channel k sends nf[k] two-beat frames; frame f carries
    // (F0 - 20h*f + k) then (E0 - 20h*f + k) with tlast.
    task automatic tx_drive(input int nf [NCH], input int b [NCH]);
        for (int k = 0; k < NCH; k++) begin
            int f;
            f           = b[k] / 2;
            s_tvalid[k] = (b[k] < 2 * nf[k]);
            s_tlast[k]  = s_tvalid[k] && (b[k] % 2 == 1);
            if (!s_tvalid[k])       s_tdata[k*DW +: DW] = 8'h00;
            else if (b[k] % 2 == 1) s_tdata[k*DW +: DW] = 8'(224 - 32 * f + k);
            else                    s_tdata[k*DW +: DW] = 8'(240 - 32 * f + k);
        end
    endtask

    task automatic tx_run(input int nf0, input int nf1, input int nf2, input int nf3);
        int             nf [NCH];
        int             b  [NCH];
        logic [NCH-1:0] hs;
        bit             done = 1'b0;
        int             cyc  = 0;
        nf[0] = nf0; nf[1] = nf1; nf[2] = nf2; nf[3] = nf3;
        for (int k = 0; k < NCH; k++) b[k] = 0;
        tx_drive(nf, b);
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (cyc == 0) check("tx_arb_cycle_valid", 32'(uart_out_tvalid), 32'd0);
            if (cyc == 1) check("tx_hdr_cycle_valid", 32'(uart_out_tvalid), 32'd1);
            hs = s_tvalid & s_tready;
            tick();
            for (int k = 0; k < NCH; k++) if (hs[k]) b[k]++;
            uart_out_tready = ($urandom_range(0, 3) != 0);
            tx_drive(nf, b);
            done = (tx_exp.size() == 0);
            for (int k = 0; k < NCH; k++) if (b[k] < 2 * nf[k]) done = 1'b0;
            cyc++;
        end
        check("tx_run_complete", 32'(done), 32'd1);
        uart_out_tready = 1'b1;
    endtask

    always @(negedge clk) begin : rx_mon
        if (mon_en && !rst) begin
            for (int k = 0; k < NCH; k++) begin
                if (m_tvalid[k]) begin
                    if (rx_exp.size() == 0) begin
                        check("rx_valid_no_frame", 32'(k), 32'hFF);
                    end else if (rx_exp[0][10:9] != 2'(k)) begin
                        check("rx_valid_channel", 32'(k), 32'(rx_exp[0][10:9]));
                    end else if (m_tready[k]) begin
                        check("rx_beat", 32'({m_tlast[k], m_tdata[k*DW +: DW]}), 32'(rx_exp[0][8:0]));
                        void'(rx_exp.pop_front());
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : tx_mon
        if (mon_en && !rst && uart_out_tvalid) begin
            if (tx_exp.size() == 0) begin
                check("tx_valid_no_frame", 32'(uart_out_tvalid), 32'd0);
            end else if (uart_out_tready) begin
                check("tx_beat", 32'({uart_out_tlast, uart_out_tdata}), 32'(tx_exp[0]));
                void'(tx_exp.pop_front());
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst             = 1'b1;
        uart_in_tdata   = '0;
        uart_in_tvalid  = 1'b0;
        uart_in_tlast   = 1'b0;
        m_tready        = '1;
        s_tdata         = '0;
        s_tvalid        = '0;
        s_tlast         = '0;
        uart_out_tready = 1'b1;

        #12;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_reset_outputs("post_rst");
        mon_en = 1'b1;

        // Valid frame to channel 2.
        rx_push(2, 1'b0, 8'hAA);
        rx_push(2, 1'b1, 8'hBB);
        rx_send(8'h02, 1'b0);
        rx_send(8'hAA, 1'b0);
        rx_send(8'hBB, 1'b1);
        check("t1_rx_sb_empty", rx_exp.size(), 32'd0);
        check("t1_drop_cnt", 32'(rx_drop_count), 32'd0);

        // Invalid id frame is swallowed whole, next frame routes normally.
        rx_send(8'h07, 1'b0);
        rx_send(8'h11, 1'b0);
        rx_send(8'h22, 1'b1);
        check("t2_drop_cnt", 32'(rx_drop_count), 32'd1);
        rx_push(1, 1'b1, 8'h33);
        rx_send(8'h01, 1'b0);
        rx_send(8'h33, 1'b1);
        check("t2_rx_sb_empty", rx_exp.size(), 32'd0);

        // Empty frame (header with tlast) is dropped and the FSM stays in header.
        rx_send(8'h03, 1'b1);
        check("t3_drop_cnt", 32'(rx_drop_count), 32'd2);
        rx_push(0, 1'b1, 8'h44);
        rx_send(8'h00, 1'b0);
        rx_send(8'h44, 1'b1);
        check("t3_rx_sb_empty", rx_exp.size(), 32'd0);

        // Egress round 1 from channels 0, 1, 3 while an ingress frame runs.
        tx_push(1'b0, 8'h00); tx_push(1'b0, 8'hF0); tx_push(1'b1, 8'hE0);
        tx_push(1'b0, 8'h01); tx_push(1'b0, 8'hF1); tx_push(1'b1, 8'hE1);
        tx_push(1'b0, 8'h03); tx_push(1'b0, 8'hF3); tx_push(1'b1, 8'hE3);
        rx_push(0, 1'b0, 8'h5A);
        rx_push(0, 1'b1, 8'hA5);
        fork
            tx_run(1, 1, 0, 1);
            begin
                rx_send(8'h00, 1'b0);
                rx_send(8'h5A, 1'b0);
                rx_send(8'hA5, 1'b1);
            end
        join
        check("t4_tx_sb_empty", tx_exp.size(), 32'd0);
        check("t4_rx_sb_empty", rx_exp.size(), 32'd0);

        // Round 2: channel 0 has two frames; channel 2 must get a turn between them.
        tx_push(1'b0, 8'h00); tx_push(1'b0, 8'hF0); tx_push(1'b1, 8'hE0);
        tx_push(1'b0, 8'h02); tx_push(1'b0, 8'hF2); tx_push(1'b1, 8'hE2);
        tx_push(1'b0, 8'h00); tx_push(1'b0, 8'hD0); tx_push(1'b1, 8'hC0);
        tx_run(2, 0, 1, 0);
        check("t4b_tx_sb_empty", tx_exp.size(), 32'd0);

        // Downstream back-pressure on channel 2 for five cycles mid-frame.
        rx_push(2, 1'b0, 8'hAA);
        rx_push(2, 1'b0, 8'hBB);
        rx_push(2, 1'b1, 8'hCC);
        rx_send(8'h02, 1'b0);
        rx_send(8'hAA, 1'b0);
        m_tready[2]    = 1'b0;
        uart_in_tdata  = 8'hBB;
        uart_in_tvalid = 1'b1;
        uart_in_tlast  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_stall_in_tready", 32'(uart_in_tready), 32'd0);
            check("t5_stall_ch2", 32'({m_tvalid[2], m_tdata[2*DW +: DW]}), 32'h1BB);
            tick();
        end
        m_tready[2] = 1'b1;
        rx_send(8'hBB, 1'b0);
        rx_send(8'hCC, 1'b1);
        check("t5_rx_sb_empty", rx_exp.size(), 32'd0);

        // Asynchronous reset with both directions mid-frame.
        mon_en = 1'b0;
        rx_send(8'h01, 1'b0);
        rx_send(8'hDD, 1'b0);
        uart_in_tdata          = 8'hEE;
        uart_in_tvalid         = 1'b1;
        s_tvalid[3]            = 1'b1;
        s_tdata[3*DW +: DW]    = 8'h77;
        s_tlast[3]             = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("t6_pre_rx_valid", 32'(m_tvalid[1]), 32'd1);
        check("t6_pre_tx_ready", 32'(s_tready[3]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        uart_in_tdata  = '0;
        uart_in_tvalid = 1'b0;
        s_tvalid       = '0;
        s_tdata        = '0;
        s_tlast        = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        rx_exp.delete();
        tx_exp.delete();
        mon_en = 1'b1;

        // Arbiter pointer was reset: channel 0 wins over channel 1 again.
        tx_push(1'b0, 8'h00); tx_push(1'b0, 8'hF0); tx_push(1'b1, 8'hE0);
        tx_push(1'b0, 8'h01); tx_push(1'b0, 8'hF1); tx_push(1'b1, 8'hE1);
        tx_run(1, 1, 0, 0);
        check("t7_tx_sb_empty", tx_exp.size(), 32'd0);

        // Drop counter saturation with back-to-back invalid one-beat frames.
        uart_in_tdata  = 8'hFF;
        uart_in_tlast  = 1'b1;
        uart_in_tvalid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("t8_drop_fffe", 32'(rx_drop_count), 32'h0000FFFE);
        tick();
        check("t8_drop_ffff", 32'(rx_drop_count), 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        check("t8_drop_sat", 32'(rx_drop_count), 32'h0000FFFF);
        check("t8_no_m_valid", 32'(m_tvalid), 32'd0);
        uart_in_tvalid = 1'b0;
        uart_in_tlast  = 1'b0;
        uart_in_tdata  = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
